// File: rtl/flash_fetch_buf_if.sv
// Fetch-side and Wishbone-side signals of the flash fetch buffer.
// The master modport is the fetch buffer itself; the slave modport is the core/flash environment.
interface flash_fetch_buf_if;
    logic        i_req;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_insn;
    logic        o_err;
    logic        o_stb;
    logic [31:0] o_addr;
    logic        o_we;
    logic [31:0] i_data;
    logic        i_ack;
    logic        i_stall;

    modport master (
        input  i_req, i_pc, i_flush, i_data, i_ack, i_stall,
        output o_valid, o_insn, o_err, o_stb, o_addr, o_we
    );

    modport slave (
        output i_req, i_pc, i_flush, i_data, i_ack, i_stall,
        input  o_valid, o_insn, o_err, o_stb, o_addr, o_we
    );
endinterface

// File: rtl/flash_fetch_buf.sv
// Instruction-fetch front end: direct-mapped word buffer in front of the SPI flash slave,
// filling misses with single-word Wishbone reads and failing slow or illegal accesses.
module flash_fetch_buf #(
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    flash_fetch_buf_if.master bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 14 - IDX_W;
    localparam int CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];
    logic [31:0]        pc_q, pc_d;
    logic               flushed_q, flushed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               o_valid_q, o_valid_d;
    logic               o_err_q, o_err_d;
    logic [31:0]        o_insn_q, o_insn_d;
    logic               o_stb_q, o_stb_d;
    logic [31:0]        o_addr_q, o_addr_d;
    logic               fill_we;

    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req_bad, req_hit;

    assign req_idx  = bus.i_pc[IDX_W+1:2];
    assign req_tag  = bus.i_pc[15:IDX_W+2];
    assign req_bad  = (bus.i_pc[1:0] != 2'b00) || (bus.i_pc[31:16] != 16'h8000);
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill_idx = pc_q[IDX_W+1:2];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        flushed_d = flushed_q;
        cnt_d     = cnt_q;
        o_valid_d = 1'b0;
        o_err_d   = o_err_q;
        o_insn_d  = o_insn_q;
        o_stb_d   = 1'b0;
        o_addr_d  = o_addr_q;
        fill_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req) begin
                    if (req_bad) begin
                        state_d   = RESP;
                        o_valid_d = 1'b1;
                        o_err_d   = 1'b1;
                        o_insn_d  = '0;
                    end else if (req_hit) begin
                        state_d   = RESP;
                        o_valid_d = 1'b1;
                        o_err_d   = 1'b0;
                        o_insn_d  = data_q[req_idx];
                    end else begin
                        state_d   = ISSUE;
                        pc_d      = bus.i_pc;
                        flushed_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                flushed_d = flushed_q | bus.i_flush;
                if (!bus.i_stall) begin
                    state_d  = WAIT;
                    o_stb_d  = 1'b1;
                    o_addr_d = pc_q;
                    cnt_d    = '0;
                end
            end
            WAIT: begin
                flushed_d = flushed_q | bus.i_flush;
                if (bus.i_ack) begin
                    // A flush seen at any point of the miss leaves the entry invalid.
                    state_d   = RESP;
                    o_valid_d = 1'b1;
                    o_err_d   = 1'b0;
                    o_insn_d  = bus.i_data;
                    fill_we   = !bus.i_flush && !flushed_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    o_valid_d = 1'b1;
                    o_err_d   = 1'b1;
                    o_insn_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fill_we) valid_d[fill_idx] = 1'b1;
        if (bus.i_flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            pc_q      <= '0;
            flushed_q <= 1'b0;
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_err_q   <= 1'b0;
            o_insn_q  <= '0;
            o_stb_q   <= 1'b0;
            o_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            flushed_q <= flushed_d;
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_err_q   <= o_err_d;
            o_insn_q  <= o_insn_d;
            o_stb_q   <= o_stb_d;
            o_addr_q  <= o_addr_d;
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= pc_q[15:IDX_W+2];
            data_q[fill_idx] <= bus.i_data;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_err   = o_err_q;
    assign bus.o_insn  = o_insn_q;
    assign bus.o_stb   = o_stb_q;
    assign bus.o_addr  = o_addr_q;
    assign bus.o_we    = 1'b0;
endmodule

// File: tb/tb_flash_fetch_buf.sv
// Directed bench for flash_fetch_buf: a per-request expectation model plus a scripted flash slave.
module tb_flash_fetch_buf;
    localparam int TIMEOUT = 255;

    logic clk;
    logic rst_n;
    flash_fetch_buf_if bus();

    flash_fetch_buf #(.IDX_W(2), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          exp_valid_cyc = -1;
    int          exp_stb_cyc   = -1;
    logic [31:0] exp_insn = '0;
    logic        exp_err  = 1'b0;
    logic [31:0] exp_addr = '0;

    int          ack_delay = -1;
    logic [31:0] rdata = '0;
    int          stb_count = 0;
    logic [31:0] last_addr = '0;

    logic        mvalid [4];
    logic [31:0] mpc    [4];
    logic [31:0] mdata  [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flash slave: acks ack_delay cycles after the strobe (-1 = never).
    initial begin
        int cd;
        cd = -1;
        bus.i_ack  = 1'b0;
        bus.i_data = '0;
        forever begin
            @(negedge clk);
            bus.i_ack = 1'b0;
            if (!rst_n) begin
                cd = -1;
            end else begin
                if (bus.o_stb) begin
                    stb_count++;
                    last_addr = bus.o_addr;
                    cd = ack_delay;
                end else if (cd > 0) begin
                    cd--;
                end
                if (cd == 0) begin
                    bus.i_ack  = 1'b1;
                    bus.i_data = rdata;
                    cd = -1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the current expectation.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk1("cmp_o_valid", bus.o_valid, cyc == exp_valid_cyc);
            chk1("cmp_o_stb", bus.o_stb, cyc == exp_stb_cyc);
            chk1("cmp_o_we", bus.o_we, 1'b0);
            if (cyc == exp_valid_cyc) begin
                chk32("cmp_o_insn", bus.o_insn, exp_insn);
                chk1("cmp_o_err", bus.o_err, exp_err);
            end
            if (cyc == exp_stb_cyc) chk32("cmp_o_addr", bus.o_addr, exp_addr);
        end
    end

    // One core fetch. d: slave ack delay (-1 never), s: stall cycles, f: flush at request-relative cycle (-1 none).
    task automatic fetch(input logic [31:0] pc, input int d, input logic [31:0] data,
                         input int s, input int f,
                         output int lat, output logic [31:0] insn, output logic err, output int nstb);
        int n, stb0;
        logic [1:0] idx;
        logic fill, done;
        @(negedge clk);
        idx  = pc[3:2];
        fill = 1'b0;
        n    = cyc;
        stb0 = stb_count;
        if (pc[1:0] != 2'b00 || pc[31:16] != 16'h8000) begin
            exp_stb_cyc = -1; exp_valid_cyc = n + 1; exp_insn = '0; exp_err = 1'b1;
        end else if (mvalid[idx] && mpc[idx] == pc) begin
            exp_stb_cyc = -1; exp_valid_cyc = n + 1; exp_insn = mdata[idx]; exp_err = 1'b0;
        end else begin
            exp_stb_cyc = n + 2 + s;
            exp_addr    = pc;
            if (d >= 0 && d < TIMEOUT) begin
                exp_valid_cyc = exp_stb_cyc + d + 1; exp_insn = data; exp_err = 1'b0; fill = 1'b1;
            end else begin
                exp_valid_cyc = exp_stb_cyc + TIMEOUT; exp_insn = '0; exp_err = 1'b1;
            end
        end
        ack_delay = d;
        rdata     = data;
        bus.i_pc    = pc;
        bus.i_req   = 1'b1;
        bus.i_flush = (f == 0);
        bus.i_stall = 1'b0;
        done = 1'b0;
        lat = -1; insn = '0; err = 1'b0;
        for (int k = 1; k <= 600 && !done; k++) begin
            @(negedge clk);
            bus.i_stall = (k <= s);
            bus.i_flush = (k == f);
            if (bus.o_valid) begin
                done = 1'b1;
                lat  = cyc - n;
                insn = bus.o_insn;
                err  = bus.o_err;
                bus.i_req   = 1'b0;
                bus.i_flush = 1'b0;
                bus.i_stall = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout pc=%h actual=no_o_valid required=o_valid", pc);
            bus.i_req = 1'b0;
            bus.i_flush = 1'b0;
            bus.i_stall = 1'b0;
        end
        nstb = stb_count - stb0;
        if (f >= 0) begin
            for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
        end else if (fill) begin
            mvalid[idx] = 1'b1; mpc[idx] = pc; mdata[idx] = data;
        end
    endtask

    initial begin
        int lat, nstb, n;
        logic [31:0] insn;
        logic err;
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_pc = '0; bus.i_flush = 1'b0; bus.i_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin mvalid[i] = 1'b0; mpc[i] = '0; mdata[i] = '0; end

        repeat (3) @(negedge clk);
        chk1("rst_o_valid", bus.o_valid, 1'b0);
        chk1("rst_o_err", bus.o_err, 1'b0);
        chk32("rst_o_insn", bus.o_insn, 32'h0);
        chk1("rst_o_stb", bus.o_stb, 1'b0);
        chk32("rst_o_addr", bus.o_addr, 32'h0);
        chk1("rst_o_we", bus.o_we, 1'b0);
        rst_n = 1'b1;

        fetch(32'h8000_0010, 74, 32'hDEAD_BEEF, 0, -1, lat, insn, err, nstb);
        chk32("t1_lat", lat, 77); chk32("t1_insn", insn, 32'hDEAD_BEEF);
        chk1("t1_err", err, 1'b0); chk32("t1_nstb", nstb, 1); chk32("t1_addr", last_addr, 32'h8000_0010);

        fetch(32'h8000_0010, 74, 32'h0, 0, -1, lat, insn, err, nstb);
        chk32("t2_lat", lat, 1); chk32("t2_insn", insn, 32'hDEAD_BEEF); chk32("t2_nstb", nstb, 0);

        fetch(32'h8000_0020, 10, 32'h1111_2222, 0, -1, lat, insn, err, nstb);
        chk32("t3a_lat", lat, 13); chk32("t3a_nstb", nstb, 1); chk32("t3a_insn", insn, 32'h1111_2222);
        fetch(32'h8000_0010, 5, 32'hCAFE_F00D, 0, -1, lat, insn, err, nstb);
        chk32("t3b_lat", lat, 8); chk32("t3b_nstb", nstb, 1); chk32("t3b_insn", insn, 32'hCAFE_F00D);

        fetch(32'h0000_1000, 3, 32'h5555_5555, 0, -1, lat, insn, err, nstb);
        chk32("t4a_lat", lat, 1); chk1("t4a_err", err, 1'b1); chk32("t4a_nstb", nstb, 0); chk32("t4a_insn", insn, 32'h0);
        fetch(32'h8000_0012, 3, 32'h5555_5555, 0, -1, lat, insn, err, nstb);
        chk32("t4b_lat", lat, 1); chk1("t4b_err", err, 1'b1); chk32("t4b_nstb", nstb, 0);

        fetch(32'h8000_0004, 2, 32'h0BAD_0004, 3, -1, lat, insn, err, nstb);
        chk32("stall_lat", lat, 8); chk32("stall_nstb", nstb, 1); chk32("stall_insn", insn, 32'h0BAD_0004);

        fetch(32'h8000_0018, -1, 32'h0, 0, -1, lat, insn, err, nstb);
        chk32("t5a_lat", lat, 257); chk1("t5a_err", err, 1'b1); chk32("t5a_insn", insn, 32'h0);
        fetch(32'h8000_0018, 1, 32'h1818_1818, 0, -1, lat, insn, err, nstb);
        chk32("t5b_lat", lat, 4); chk32("t5b_nstb", nstb, 1); chk1("t5b_err", err, 1'b0);

        fetch(32'h8000_0004, 9, 32'h0, 0, 0, lat, insn, err, nstb);
        chk32("flush_hit_lat", lat, 1); chk32("flush_hit_insn", insn, 32'h0BAD_0004);
        fetch(32'h8000_0004, 20, 32'h4444_0004, 0, 7, lat, insn, err, nstb);
        chk32("t6a_lat", lat, 23); chk32("t6a_insn", insn, 32'h4444_0004); chk32("t6a_nstb", nstb, 1);
        fetch(32'h8000_0004, 0, 32'h7777_0004, 0, -1, lat, insn, err, nstb);
        chk32("t6b_lat", lat, 3); chk32("t6b_nstb", nstb, 1); chk32("t6b_insn", insn, 32'h7777_0004);
        fetch(32'h8000_0004, 0, 32'h0, 0, -1, lat, insn, err, nstb);
        chk32("t6c_lat", lat, 1); chk32("t6c_insn", insn, 32'h7777_0004);

        // Reset in the middle of a bus wait.
        @(negedge clk);
        n = cyc;
        exp_stb_cyc = n + 2; exp_addr = 32'h8000_0008; exp_valid_cyc = -1;
        ack_delay = 30; rdata = 32'h9999_0008;
        bus.i_pc = 32'h8000_0008; bus.i_req = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("rstw_o_valid", bus.o_valid, 1'b0);
        chk1("rstw_o_err", bus.o_err, 1'b0);
        chk32("rstw_o_insn", bus.o_insn, 32'h0);
        chk1("rstw_o_stb", bus.o_stb, 1'b0);
        chk32("rstw_o_addr", bus.o_addr, 32'h0);
        chk1("rstw_o_we", bus.o_we, 1'b0);
        bus.i_req = 1'b0;
        exp_stb_cyc = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
        fetch(32'h8000_0004, 4, 32'h2468_0004, 0, -1, lat, insn, err, nstb);
        chk32("post_rst_nstb", nstb, 1); chk32("post_rst_lat", lat, 7); chk32("post_rst_insn", insn, 32'h2468_0004);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
